// File: rtl/ysyx_24080014_pkg.sv
// Shared definitions for the ysyx_24080014 core: IFU state encoding,
// AXI response codes and the instruction word presented on an access fault.
package ysyx_24080014_pkg;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_AR   = 2'd1,
        IFU_R    = 2'd2,
        IFU_OUT  = 2'd3
    } ifu_state_e;

    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
    localparam logic [31:0] INST_FAULT    = 32'h0000_0000;

    // An instruction fetch must be word aligned; any set low bit is a fault.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/ysyx_24080014_ifu.sv
// Instruction fetch unit: takes a pc from the PC stage, performs one
// single-beat AXI4-Lite read and hands {inst, inst_pc, fault} to decode
// through a valid/ready handshake. A flush discards whatever is in flight;
// a read already issued on the bus is still completed, then thrown away.
module ysyx_24080014_ifu
    import ysyx_24080014_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    input  logic              flush,
    output logic              busy,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [INST_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              fault
);

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q;
    logic [INST_W-1:0] inst_q;
    logic [ADDR_W-1:0] inst_pc_q;
    logic              fault_q;
    logic              drop_q;

    // Next-state selection for the fetch sequence IDLE -> AR -> R -> OUT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IFU_IDLE: begin
                if (pc_valid && !flush) begin
                    state_d = is_misaligned(pc[1:0]) ? IFU_OUT : IFU_AR;
                end else begin
                    state_d = IFU_IDLE;
                end
            end
            IFU_AR: begin
                if (arready) begin
                    state_d = IFU_R;
                end else begin
                    state_d = IFU_AR;
                end
            end
            IFU_R: begin
                if (rvalid) begin
                    state_d = (drop_q || flush) ? IFU_IDLE : IFU_OUT;
                end else begin
                    state_d = IFU_R;
                end
            end
            IFU_OUT: begin
                if (flush || out_ready) begin
                    state_d = IFU_IDLE;
                end else begin
                    state_d = IFU_OUT;
                end
            end
            default: state_d = IFU_IDLE;
        endcase
    end

    // State register; reset abandons any transaction immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IFU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request address, output payload and the pending-drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr_q <= {ADDR_W{1'b0}};
            inst_q     <= {INST_W{1'b0}};
            inst_pc_q  <= {ADDR_W{1'b0}};
            fault_q    <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            case (state_q)
                IFU_IDLE: begin
                    if (pc_valid && !flush) begin
                        if (is_misaligned(pc[1:0])) begin
                            // Misaligned pc never reaches the bus.
                            inst_q    <= INST_W'(INST_FAULT);
                            inst_pc_q <= pc;
                            fault_q   <= 1'b1;
                        end else begin
                            req_addr_q <= pc;
                        end
                    end else begin
                        req_addr_q <= req_addr_q;
                    end
                end
                IFU_AR: begin
                    // arvalid must stay up once raised, so a flush is only remembered.
                    if (flush) begin
                        drop_q <= 1'b1;
                    end else begin
                        drop_q <= drop_q;
                    end
                end
                IFU_R: begin
                    if (rvalid) begin
                        if (drop_q || flush) begin
                            drop_q <= 1'b0;
                        end else begin
                            inst_q    <= (rresp != AXI_RESP_OKAY) ? INST_W'(INST_FAULT) : rdata;
                            inst_pc_q <= req_addr_q;
                            fault_q   <= (rresp != AXI_RESP_OKAY);
                        end
                    end else if (flush) begin
                        drop_q <= 1'b1;
                    end else begin
                        drop_q <= drop_q;
                    end
                end
                IFU_OUT: begin
                    inst_q <= inst_q;
                end
                default: begin
                    drop_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = (state_q != IFU_IDLE);
    assign arvalid   = (state_q == IFU_AR);
    assign rready    = (state_q == IFU_R);
    assign out_valid = (state_q == IFU_OUT);
    assign araddr    = req_addr_q;
    assign inst      = inst_q;
    assign inst_pc   = inst_pc_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_ysyx_24080014_ifu.sv
// Self-checking bench for the instruction fetch unit. The bench plays the
// PC stage, the AXI slave and the decode stage; each fetch is described as a
// transaction (pc, data, response, stall lengths, where a flush lands) and
// the expected interface behaviour is derived from that description.
module tb_ysyx_24080014_ifu;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic        busy;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fault;

    int vectors;
    int miscompares;
    int ar_hs;
    int ar_cycles;

    // Flush placement codes for run_txn.
    localparam int F_NONE = 0;
    localparam int F_AR   = 1;
    localparam int F_R    = 2;
    localparam int F_OUT  = 3;

    ysyx_24080014_ifu #(.ADDR_W(32), .INST_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .pc_valid  (pc_valid),
        .flush     (flush),
        .busy      (busy),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst      (inst),
        .inst_pc   (inst_pc),
        .fault     (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus-side observation: AR handshakes and cycles with arvalid high.
    always @(posedge clk) begin
        if (!rst && arvalid && arready) ar_hs <= ar_hs + 1;
        if (!rst && arvalid) ar_cycles <= ar_cycles + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        pc_valid  = 1'b0;
        flush     = 1'b0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rdata     = 32'h0;
        rresp     = 2'b00;
        out_ready = 1'b0;
    endtask

    // One fetch seen from all three neighbours. ctl = {busy,arvalid,rready,out_valid}.
    task automatic run_txn(input logic [31:0] p, input logic [31:0] d, input logic [1:0] resp,
                           input int ard, input int rd, input int ord, input int fmode,
                           input string name);
        logic        mis;
        logic        exp_fault;
        logic [31:0] exp_inst;
        logic        dropped;
        int          c;
        mis       = (p % 4) != 0;
        exp_fault = mis || (resp != 2'b00);
        exp_inst  = exp_fault ? 32'h0 : d;
        dropped   = !mis && (fmode == F_AR || fmode == F_R);

        vectors++;
        if ({busy, arvalid, rready, out_valid} !== 4'b0000) begin
            miscompares++;
            $display("FAIL %s idle_before: ctl=%b want 0000", name, {busy, arvalid, rready, out_valid});
        end
        pc = p;
        pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;

        if (!mis) begin
            c = 0;
            forever begin
                vectors++;
                if ({busy, arvalid, rready, out_valid} !== 4'b1100 || araddr !== p) begin
                    miscompares++;
                    $display("FAIL %s ar_phase c=%0d: ctl=%b araddr=%h want 1100 %h",
                             name, c, {busy, arvalid, rready, out_valid}, araddr, p);
                end
                flush   = (fmode == F_AR && c == 0);
                arready = (c >= ard);
                @(negedge clk);
                if (arready) break;
                c++;
            end
            arready = 1'b0;
            flush   = 1'b0;
            c = 0;
            forever begin
                vectors++;
                if ({busy, arvalid, rready, out_valid} !== 4'b1010) begin
                    miscompares++;
                    $display("FAIL %s r_phase c=%0d: ctl=%b want 1010", name, c,
                             {busy, arvalid, rready, out_valid});
                end
                flush  = (fmode == F_R && c == 0);
                rvalid = (c >= rd);
                rdata  = rvalid ? d : $urandom;
                rresp  = rvalid ? resp : 2'($urandom_range(0, 3));
                @(negedge clk);
                if (rvalid) break;
                c++;
            end
            rvalid = 1'b0;
            flush  = 1'b0;
        end

        if (dropped) begin
            vectors++;
            if ({busy, arvalid, rready, out_valid} !== 4'b0000) begin
                miscompares++;
                $display("FAIL %s drop_done: ctl=%b want 0000", name, {busy, arvalid, rready, out_valid});
            end
        end else begin
            c = 0;
            forever begin
                vectors++;
                if ({busy, arvalid, rready, out_valid, inst, inst_pc, fault} !==
                    {4'b1001, exp_inst, p, exp_fault}) begin
                    miscompares++;
                    $display("FAIL %s out_phase c=%0d: ctl=%b inst=%h pc=%h fault=%b want 1001 %h %h %b",
                             name, c, {busy, arvalid, rready, out_valid}, inst, inst_pc, fault,
                             exp_inst, p, exp_fault);
                end
                if (fmode == F_OUT && c >= ord) begin
                    flush     = 1'b1;
                    out_ready = 1'($urandom_range(0, 1));
                end else begin
                    out_ready = (c >= ord);
                end
                @(negedge clk);
                if (c >= ord) break;
                c++;
            end
            out_ready = 1'b0;
            flush     = 1'b0;
            vectors++;
            if ({busy, arvalid, rready, out_valid} !== 4'b0000) begin
                miscompares++;
                $display("FAIL %s out_done: ctl=%b want 0000", name, {busy, arvalid, rready, out_valid});
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        pc = 32'h0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, arvalid, rready, out_valid, inst, inst_pc, fault} !== {4'b0000, 32'h0, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: ctl=%b inst=%h pc=%h fault=%b want all zero",
                     {busy, arvalid, rready, out_valid}, inst, inst_pc, fault);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_txn(32'h8000_0000, 32'h0000_0413, 2'b00, 0, 0, 0, F_NONE, "basic");
    endtask

    task automatic test_ar_stall();
        int hs0;
        hs0 = ar_hs;
        run_txn(32'h8000_0010, 32'h1234_5678, 2'b00, 4, 0, 0, F_NONE, "ar_stall");
        vectors++;
        if (ar_hs - hs0 !== 1) begin
            miscompares++;
            $display("FAIL ar_stall_handshakes: got %0d want 1", ar_hs - hs0);
        end
    endtask

    task automatic test_out_stall();
        run_txn(32'h8000_0020, 32'hcafe_f00d, 2'b00, 0, 1, 5, F_NONE, "out_stall");
    endtask

    task automatic test_flush_ar();
        run_txn(32'h8000_0000, 32'hdead_beef, 2'b00, 2, 1, 0, F_AR, "flush_ar");
        run_txn(32'h8000_0004, 32'h0050_0093, 2'b00, 0, 0, 0, F_NONE, "after_flush");
    endtask

    task automatic test_flush_idle();
        flush    = 1'b1;
        pc       = 32'h8000_0100;
        pc_valid = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        pc_valid = 1'b0;
        vectors++;
        if ({busy, arvalid, rready, out_valid} !== 4'b0000) begin
            miscompares++;
            $display("FAIL flush_idle: ctl=%b want 0000", {busy, arvalid, rready, out_valid});
        end
    endtask

    task automatic test_fault();
        int cyc0;
        run_txn(32'h8000_0008, 32'hffff_ffff, 2'b10, 1, 2, 1, F_NONE, "rresp_fault");
        cyc0 = ar_cycles;
        run_txn(32'h8000_0002, 32'h0, 2'b00, 0, 0, 2, F_NONE, "misaligned");
        vectors++;
        if (ar_cycles !== cyc0) begin
            miscompares++;
            $display("FAIL misaligned_no_ar: arvalid cycles %0d want %0d", ar_cycles, cyc0);
        end
    endtask

    task automatic test_reset_in_r();
        pc       = 32'h8000_0040;
        pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        arready  = 1'b1;
        @(negedge clk);
        arready  = 1'b0;
        vectors++;
        if ({busy, arvalid, rready, out_valid} !== 4'b1010) begin
            miscompares++;
            $display("FAIL reset_in_r_setup: ctl=%b want 1010", {busy, arvalid, rready, out_valid});
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, arvalid, rready, out_valid} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_in_r: ctl=%b want 0000", {busy, arvalid, rready, out_valid});
        end
        rst = 1'b0;
        @(negedge clk);
        run_txn(32'h8000_0044, 32'h0010_0073, 2'b00, 0, 0, 0, F_NONE, "after_reset");
    endtask

    task automatic test_random();
        int          hs0;
        int          exp_hs;
        logic [31:0] p;
        logic [1:0]  resp;
        int          fm;
        hs0    = ar_hs;
        exp_hs = 0;
        for (int i = 0; i < 60; i++) begin
            p = {2'b10, 28'($urandom), 2'b00};
            if ($urandom_range(0, 4) == 0) p[1:0] = 2'($urandom_range(1, 3));
            resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            fm   = ($urandom_range(0, 1) == 0) ? F_NONE : $urandom_range(1, 3);
            if (p[1:0] == 2'b00) exp_hs++;
            run_txn(p, $urandom, resp, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), fm, "random");
        end
        vectors++;
        if (ar_hs - hs0 !== exp_hs) begin
            miscompares++;
            $display("FAIL random_handshakes: got %0d want %0d", ar_hs - hs0, exp_hs);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        ar_hs       = 0;
        ar_cycles   = 0;
        test_reset();
        test_basic();
        test_ar_stall();
        test_out_stall();
        test_flush_ar();
        test_flush_idle();
        test_fault();
        test_reset_in_r();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
